// File: rtl/lights_request_scheduler.sv
// Round-robin arbiter that lends one lights selector to N_REQ requesters: steps the
// colour counter until the fed-back light matches the granted target, holds it, then releases.
module lights_request_scheduler #(
   parameter int N_REQ       = 4,
   parameter int HOLD_CYCLES = 8,
   parameter int SETTLE      = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [3*N_REQ-1:0] req_colour,
   input  logic [2:0]         light_in,
   output logic               button,
   output logic               sel,
   output logic [N_REQ-1:0]   grant,
   output logic               done,
   output logic               err,
   output logic               busy
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
   localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
   localparam logic [IW-1:0] PTR_INIT    = IW'(N_REQ - 1);
   localparam logic [2:0]    MAX_STEPS   = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_COMPARE = 3'd2,
      ST_STEP    = 3'd3,
      ST_HOLD    = 3'd4
   } state_t;

   function automatic logic colour_legal(input logic [2:0] c);
      return (c != 3'b000) && (c != 3'b111);
   endfunction

   state_t            state_r, state_s;
   logic [N_REQ-1:0]  grant_r, grant_s;
   logic [IW-1:0]     gidx_r, gidx_s;
   logic [IW-1:0]     ptr_r, ptr_s;
   logic [2:0]        target_r, target_s;
   logic [2:0]        step_cnt_r, step_cnt_s;
   logic [SW-1:0]     settle_cnt_r, settle_cnt_s;
   logic [HW-1:0]     hold_cnt_r, hold_cnt_s;
   logic              button_r, button_s;
   logic              sel_r, sel_s;
   logic              done_r, done_s;
   logic              err_r, err_s;
   logic              busy_r, busy_s;

   logic [2:0]        colour_arr_s [N_REQ];
   logic              found_s;
   logic [IW-1:0]     win_idx_s;
   logic [IW-1:0]     cand_s;

   for (genvar g = 0; g < N_REQ; g++) begin : g_colour
      assign colour_arr_s[g] = req_colour[3*g +: 3];
   end

   // Round-robin search: first asserted request after the pointer, wrapping.
   always_comb begin
      found_s   = 1'b0;
      win_idx_s = '0;
      cand_s    = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand_s = IW'((int'(ptr_r) + i) % N_REQ);
         if (!found_s && req[cand_s]) begin
            found_s   = 1'b1;
            win_idx_s = cand_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next-state and next-output logic; every output is re-registered below.
   always_comb begin
      state_s      = state_r;
      grant_s      = grant_r;
      gidx_s       = gidx_r;
      ptr_s        = ptr_r;
      target_s     = target_r;
      step_cnt_s   = step_cnt_r;
      settle_cnt_s = settle_cnt_r;
      hold_cnt_s   = hold_cnt_r;
      button_s     = 1'b0;
      sel_s        = sel_r;
      done_s       = 1'b0;
      err_s        = 1'b0;

      if (state_r == ST_IDLE) begin
         sel_s = 1'b1;
         if (found_s) begin
            grant_s            = '0;
            grant_s[win_idx_s] = 1'b1;
            gidx_s             = win_idx_s;
            target_s           = colour_arr_s[win_idx_s];
            step_cnt_s         = 3'd0;
            settle_cnt_s       = '0;
            sel_s              = 1'b0;
            state_s            = ST_SETTLE;
         end else begin
            grant_s = '0;
         end
      end else if (!req[gidx_r] || !colour_legal(target_r)) begin
         // Withdrawn request or unreachable colour: release immediately.
         err_s   = 1'b1;
         grant_s = '0;
         sel_s   = 1'b1;
         ptr_s   = gidx_r;
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_SETTLE: begin
               if (settle_cnt_r == SETTLE_LAST) begin
                  state_s = ST_COMPARE;
               end else begin
                  settle_cnt_s = settle_cnt_r + SW'(1);
               end
            end
            ST_COMPARE: begin
               if (light_in == target_r) begin
                  hold_cnt_s = '0;
                  state_s    = ST_HOLD;
               end else if (step_cnt_r == MAX_STEPS) begin
                  err_s   = 1'b1;
                  grant_s = '0;
                  sel_s   = 1'b1;
                  ptr_s   = gidx_r;
                  state_s = ST_IDLE;
               end else begin
                  button_s   = 1'b1;
                  step_cnt_s = step_cnt_r + 3'd1;
                  state_s    = ST_STEP;
               end
            end
            ST_STEP: begin
               settle_cnt_s = '0;
               state_s      = ST_SETTLE;
            end
            ST_HOLD: begin
               sel_s = 1'b0;
               if (hold_cnt_r == HOLD_LAST) begin
                  done_s  = 1'b1;
                  grant_s = '0;
                  sel_s   = 1'b1;
                  ptr_s   = gidx_r;
                  state_s = ST_IDLE;
               end else begin
                  hold_cnt_s = hold_cnt_r + HW'(1);
               end
            end
            default: begin
               grant_s = '0;
               sel_s   = 1'b1;
               state_s = ST_IDLE;
            end
         endcase
      end

      busy_s = (state_s != ST_IDLE);
   end

   // State and registered outputs with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         grant_r      <= '0;
         gidx_r       <= '0;
         ptr_r        <= PTR_INIT;
         target_r     <= 3'b000;
         step_cnt_r   <= 3'd0;
         settle_cnt_r <= '0;
         hold_cnt_r   <= '0;
         button_r     <= 1'b0;
         sel_r        <= 1'b1;
         done_r       <= 1'b0;
         err_r        <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         grant_r      <= grant_s;
         gidx_r       <= gidx_s;
         ptr_r        <= ptr_s;
         target_r     <= target_s;
         step_cnt_r   <= step_cnt_s;
         settle_cnt_r <= settle_cnt_s;
         hold_cnt_r   <= hold_cnt_s;
         button_r     <= button_s;
         sel_r        <= sel_s;
         done_r       <= done_s;
         err_r        <= err_s;
         busy_r       <= busy_s;
      end
   end

   assign button = button_r;
   assign sel    = sel_r;
   assign grant  = grant_r;
   assign done   = done_r;
   assign err    = err_r;
   assign busy   = busy_r;

endmodule

// File: tb/tb_lights_request_scheduler.sv
// Directed bench for lights_request_scheduler with a behavioural lights-selector model
// (counter 001..110 stepped by button, white when sel is high).
module tb_lights_request_scheduler;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [11:0] req_colour;
   logic [2:0]  light_in;
   logic        button;
   logic        sel;
   logic [3:0]  grant;
   logic        done;
   logic        err;
   logic        busy;

   logic [2:0]  cnt;
   logic        btn_conn;
   int          checks;
   int          passes;
   int          w_cyc;
   int          w_pulses;
   int          pulse_cyc [8];
   logic [3:0]  w_first_grant;
   logic [3:0]  rr_exp [5];

   lights_request_scheduler #(.N_REQ(4), .HOLD_CYCLES(8), .SETTLE(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_colour (req_colour),
      .light_in   (light_in),
      .button     (button),
      .sel        (sel),
      .grant      (grant),
      .done       (done),
      .err        (err),
      .busy       (busy)
   );

   assign light_in = sel ? 3'b111 : cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; the selector model reacts to a button pulse seen during the ending cycle.
   task automatic step_clk();
      logic b;
      b = button;
      @(posedge clk);
      #1;
      w_cyc++;
      if (b) begin
         if (w_pulses < 8) pulse_cyc[w_pulses] = w_cyc - 1;
         w_pulses++;
         if (btn_conn) cnt = (cnt == 3'd6) ? 3'd1 : cnt + 3'd1;
      end
   endtask

   // Runs from the cycle req was set until done or err, bounded.
   task automatic wait_end(input int drop_after);
      bit got;
      got           = 1'b0;
      w_cyc         = 0;
      w_pulses      = 0;
      w_first_grant = 4'b0000;
      while (!got && w_cyc < 100) begin
         step_clk();
         if (w_cyc == 1) w_first_grant = grant;
         if (drop_after != 0 && w_pulses == drop_after) req = 4'b0000;
         if (done || err) got = 1'b1;
      end
      check_val("end_seen", 32'(got), 32'd1);
      check_val("done_err_excl", 32'(done & err), 32'd0);
   endtask

   initial begin
      checks     = 0;
      passes     = 0;
      w_cyc      = 0;
      w_pulses   = 0;
      rst        = 1'b1;
      req        = 4'b0000;
      req_colour = 12'h000;
      cnt        = 3'd1;
      btn_conn   = 1'b1;
      rr_exp     = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_grant", 32'(grant), 32'h0);
      check_val("rst_sel", 32'(sel), 32'd1);
      check_val("rst_button", 32'(button), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done_err", 32'({done, err}), 32'd0);
      rst = 1'b0;

      // req0 wants 100 from counter 001: three steps
      req_colour = {3'b000, 3'b000, 3'b000, 3'b100};
      req        = 4'b0001;
      wait_end(0);
      check_val("t1_grant", 32'(w_first_grant), 32'h1);
      check_val("t1_done", 32'(done), 32'd1);
      check_val("t1_latency", 32'(w_cyc), 32'd20);
      check_val("t1_pulses", 32'(w_pulses), 32'd3);
      check_val("t1_pulse0", 32'(pulse_cyc[0]), 32'd3);
      check_val("t1_pulse1", 32'(pulse_cyc[1]), 32'd6);
      check_val("t1_pulse2", 32'(pulse_cyc[2]), 32'd9);
      check_val("t1_grant_drop", 32'(grant), 32'h0);
      check_val("t1_sel", 32'(sel), 32'd1);
      check_val("t1_busy", 32'(busy), 32'd0);
      req = 4'b0000;
      step_clk();
      check_val("t1_done_1cyc", 32'(done), 32'd0);

      // asynchronous reset while holding
      req_colour = {3'b000, 3'b000, 3'b000, 3'b100};
      req        = 4'b0001;
      w_cyc      = 0;
      repeat (5) step_clk();
      check_val("rh_busy_pre", 32'(busy), 32'd1);
      check_val("rh_sel_pre", 32'(sel), 32'd0);
      #2 rst = 1'b1;
      #1;
      check_val("rh_grant", 32'(grant), 32'h0);
      check_val("rh_sel", 32'(sel), 32'd1);
      check_val("rh_button", 32'(button), 32'd0);
      check_val("rh_busy", 32'(busy), 32'd0);
      cnt        = 3'd2;
      req_colour = {4{3'b010}};
      req        = 4'b1111;
      #7 rst = 1'b0;

      // round robin across all four requesters, colour already showing
      for (int k = 0; k < 5; k++) begin
         wait_end(0);
         check_val("rr_grant", 32'(w_first_grant), 32'(rr_exp[k]));
         check_val("rr_done", 32'(done), 32'd1);
         check_val("rr_latency", 32'(w_cyc), 32'd11);
         check_val("rr_pulses", 32'(w_pulses), 32'd0);
      end
      req = 4'b0000;
      step_clk();

      // illegal colours abort right after the grant
      for (int k = 0; k < 2; k++) begin
         req_colour = (k == 0) ? {3'b000, 3'b111, 3'b000, 3'b000} : 12'h000;
         req        = 4'b0100;
         wait_end(0);
         check_val("ill_grant", 32'(w_first_grant), 32'h4);
         check_val("ill_err", 32'(err), 32'd1);
         check_val("ill_cycle", 32'(w_cyc), 32'd2);
         check_val("ill_pulses", 32'(w_pulses), 32'd0);
         check_val("ill_grant_drop", 32'(grant), 32'h0);
         req = 4'b0000;
         step_clk();
      end

      // selector stuck: six steps then give up
      btn_conn   = 1'b0;
      cnt        = 3'd1;
      req_colour = {3'b000, 3'b000, 3'b101, 3'b000};
      req        = 4'b0010;
      wait_end(0);
      check_val("stk_grant", 32'(w_first_grant), 32'h2);
      check_val("stk_err", 32'(err), 32'd1);
      check_val("stk_cycle", 32'(w_cyc), 32'd21);
      check_val("stk_pulses", 32'(w_pulses), 32'd6);
      check_val("stk_sel", 32'(sel), 32'd1);
      check_val("stk_busy", 32'(busy), 32'd0);
      req      = 4'b0000;
      btn_conn = 1'b1;
      step_clk();

      // req3 withdrawn after its second step
      cnt        = 3'd1;
      req_colour = {3'b110, 3'b000, 3'b000, 3'b000};
      req        = 4'b1000;
      wait_end(2);
      check_val("drop_grant", 32'(w_first_grant), 32'h8);
      check_val("drop_err", 32'(err), 32'd1);
      check_val("drop_cycle", 32'(w_cyc), 32'd8);
      check_val("drop_grant_drop", 32'(grant), 32'h0);
      repeat (6) step_clk();
      check_val("drop_no_more_pulses", 32'(w_pulses), 32'd2);
      check_val("drop_idle", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/lights_request_scheduler.md
Name: lights_request_scheduler

Overview:
- Round-robin scheduler that shares one lights selector (colour counter stepped by `button`, white override by `sel`) among N_REQ requesters.
- Grants one requester at a time.
- Pulses `button` until the selector's `light` feedback matches the requested colour, holds it for HOLD_CYCLES, then signals `done`.
- Sits between the requester logic and the lights selector instance; owns that instance's `button` and `sel` inputs.

Parameters:
N_REQ, 4, number of requesters (2..8)
HOLD_CYCLES, 8, cycles the matched colour is displayed before release (>=1)
SETTLE, 1, cycles waited after any button pulse or sel change before light_in is compared (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  N_REQ  request per requester; level, held until done/err
req_colour  input  3*N_REQ  requested colour, requester i at bits [3i+2:3i]; legal 3'b001..3'b110
light_in  input  3  light output fed back from lights selector
button  output  1  one-cycle step pulse to lights selector
sel  output  1  1 = white override (light 3'b111), 0 = colour counter shown
grant  output  N_REQ  one-hot grant, all zero when idle
done  output  1  one-cycle pulse: granted request completed
err  output  1  one-cycle pulse: granted request aborted
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state): state=IDLE, grant=0, button=0, sel=1, done=0, err=0, busy=0, step count=0, RR pointer=N_REQ-1, so requester 0 wins first.
- All outputs registered.
- States: IDLE, SETTLE, COMPARE, STEP, HOLD.
- IDLE:
  - sel=1.
  - If any req, the next cycle: grant = first asserted req searching from pointer+1 with wrap; target latched from req_colour; sel=0; state=SETTLE.
  - If the latched target is illegal (3'b000 or 3'b111): go straight to IDLE next cycle with err pulse, grant cleared, pointer advanced.
- SETTLE: count SETTLE cycles, then COMPARE.
- COMPARE:
  - light_in==target: state=HOLD.
  - Else if step count==6: err pulse, grant=0, sel=1, pointer=granted index, state=IDLE.
  - Else: state=STEP.
- STEP: button=1 for exactly this one cycle, step count+1, state=SETTLE.
- HOLD:
  - sel=0, counts HOLD_CYCLES cycles.
  - On the last cycle: done pulses in the same cycle grant drops to 0, sel returns to 1, pointer=granted index, state=IDLE.
- Step count clears on every new grant; at most 6 button pulses per grant.
- Latency: target already showing with SETTLE=1 gives grant at cycle 1, HOLD entered at cycle 3, done at cycle 2+HOLD_CYCLES+1.
- Requester drops req while granted (any non-IDLE state):
  - Abort next cycle: err pulse, grant=0, sel=1, button=0, state=IDLE, pointer advanced.
  - A button pulse already issued is not undone.
- New req arriving while busy is queued implicitly: req stays high.
- Simultaneous done/err and new req: IDLE needs one cycle, so no back-to-back grant in the same cycle as done.
- A requester must not be granted twice in a row while another req is asserted (round-robin fairness).
- grant always zero- or one-hot; button never high outside STEP; done and err never high together.

Test Plan:
- Bench uses a behavioural lights-selector model: counter 001..110 wrapping to 001 on button, light = sel ? 111 : counter.
- Reset mid-HOLD (rst pulsed 1 cycle asynchronously) -> same edge: grant=0, sel=1, button=0, busy=0; next req0 served first.
- Model counter=001, req0 with colour 100 -> exactly 3 button pulses, each 1 cycle, separated by SETTLE+1 cycles; light_in=100 for 8 cycles with sel=0; then done=1 for one cycle, grant 0001→0000.
- req=4'b1111, all colours 010, counter=010 -> grants in order 0001, 0010, 0100, 1000, 0001; each done with zero button pulses.
- req2 colour 111 -> grant 0100 for one cycle, err pulse, no button pulses; req2 colour 000 behaves the same.
- Model with button disconnected (counter stuck at 001), req1 colour 101 -> 6 button pulses then err, sel=1, busy=0.
- req3 deasserted after the 2nd button pulse -> err next cycle, grant=0, no further button pulses.
